// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract split into STAGES equal slices.
// Each stage adds one slice, registers its carry, and carries the operand bits
// that later slices still need. Valid/ready handshake on both ends; a stage
// moves forward whenever the stage after it can take its contents.
`timescale 1ns/1ps

module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int S    = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    generate
        if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
            $error("pipelined_adder: WIDTH must be a multiple of STAGES, with 1 <= STAGES <= WIDTH");
        end
    endgenerate

    // Per-stage registers. Index k holds the state of pipeline stage k+1.
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic              msbc_q;   // carry into bit WIDTH-1, captured by the final stage
    logic              run_q;    // low until the first clock after reset release

    // Per-stage inputs and next-state values.
    logic [STAGES-1:0] stage_rdy;
    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] src_c;
    logic [WIDTH-1:0]  src_a   [STAGES];
    logic [WIDTH-1:0]  src_b   [STAGES];
    logic [WIDTH-1:0]  src_sum [STAGES];
    logic [WIDTH-1:0]  nxt_sum [STAGES];
    logic [STAGES-1:0] nxt_c;
    logic              nxt_msbc;

    // Ready chain: a stage can advance unless it and every stage after it are
    // full while the consumer stalls. Written as a scan over the valid flags
    // so no ready bit depends on another ready bit.
    always_comb begin
        logic full_tail;
        full_tail = 1'b1;
        stage_rdy = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            full_tail            = full_tail & v_q[LAST - i];
            stage_rdy[LAST - i]  = out_ready | ~full_tail;
        end
    end

    // Select what each stage would load: the input port for stage 1, the
    // previous stage's registers otherwise. Subtraction becomes A + ~B + 1 here.
    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            src_v[k]   = 1'b0;
            src_c[k]   = 1'b0;
            src_a[k]   = '0;
            src_b[k]   = '0;
            src_sum[k] = '0;
        end
        src_v[0]   = in_valid & run_q;
        src_a[0]   = in_a;
        src_b[0]   = in_sub ? ~in_b : in_b;
        src_c[0]   = in_sub | in_cin;
        src_sum[0] = '0;
        for (int unsigned k = 1; k < STAGES; k++) begin
            src_v[k]   = v_q[k-1];
            src_a[k]   = a_q[k-1];
            src_b[k]   = b_q[k-1];
            src_c[k]   = c_q[k-1];
            src_sum[k] = sum_q[k-1];
        end
    end

    // Slice adders: stage k+1 adds operand bits [k*S +: S] with the carry from
    // the stage before it and merges the result into the partial sum.
    always_comb begin
        logic [S:0] slice;
        slice    = '0;
        nxt_msbc = 1'b0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            slice = {1'b0, src_a[k][k*S +: S]}
                  + {1'b0, src_b[k][k*S +: S]}
                  + {{S{1'b0}}, src_c[k]};
            nxt_sum[k]             = src_sum[k];
            nxt_sum[k][k*S +: S]   = slice[S-1:0];
            nxt_c[k]               = slice[S];
            if (k == LAST) begin
                // Sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out
                // of the MSB sum bit and the two operand MSBs.
                nxt_msbc = slice[S-1] ^ src_a[k][WIDTH-1] ^ src_b[k][WIDTH-1];
            end
        end
    end

    // Pipeline registers: a ready stage takes its source valid flag, and its
    // data only when that source is valid; a stalled stage holds everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= 1'b0;
            v_q    <= '0;
            c_q    <= '0;
            msbc_q <= 1'b0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                sum_q[k] <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
            end
        end else begin
            run_q <= 1'b1;
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (stage_rdy[k]) begin
                    v_q[k] <= src_v[k];
                    if (src_v[k]) begin
                        sum_q[k] <= nxt_sum[k];
                        c_q[k]   <= nxt_c[k];
                        if (k != LAST) begin
                            a_q[k] <= src_a[k];
                            b_q[k] <= src_b[k];
                        end
                    end
                end
            end
            if (stage_rdy[LAST] && src_v[LAST]) begin
                msbc_q <= nxt_msbc;
            end
        end
    end

    assign in_ready  = stage_rdy[0] & run_q;
    assign out_valid = v_q[LAST];
    assign out_sum   = sum_q[LAST];
    assign out_cout  = c_q[LAST];
    assign out_ovf   = msbc_q ^ c_q[LAST];

endmodule

// File: tb/tb_pipelined_adder.sv
// Testbench for pipelined_adder: WIDTH=8 with STAGES=4 (main), 1 and 8 side by side.
`timescale 1ns/1ps

module tb_pipelined_adder;

    localparam int STG [3] = '{4, 1, 8};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid, in_cin, in_sub;
    logic [7:0] in_a, in_b;
    logic       out_ready0;

    logic [2:0] i_ready, o_valid, o_ready, o_cout, o_ovf;
    logic [7:0] o_sum [3];

    assign o_ready = {1'b1, 1'b1, out_ready0};

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(8), .STAGES(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(i_ready[0]),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(o_valid[0]), .out_ready(o_ready[0]), .out_sum(o_sum[0]),
        .out_cout(o_cout[0]), .out_ovf(o_ovf[0]));

    pipelined_adder #(.WIDTH(8), .STAGES(1)) u_dut_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(i_ready[1]),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(o_valid[1]), .out_ready(o_ready[1]), .out_sum(o_sum[1]),
        .out_cout(o_cout[1]), .out_ovf(o_ovf[1]));

    pipelined_adder #(.WIDTH(8), .STAGES(8)) u_dut_s8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(i_ready[2]),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(o_valid[2]), .out_ready(o_ready[2]), .out_sum(o_sum[2]),
        .out_cout(o_cout[2]), .out_ovf(o_ovf[2]));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int pops0   = 0;
    bit lat_chk = 1'b0;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        string      name;
    } vec_t;

    exp_t sbq [3][$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Golden model: plain integer arithmetic, signed range check for overflow.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic cin, input logic sub);
        exp_t e;
        int ua, ub, sa, sb, ur, sr;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            ur     = ua - ub;
            sr     = sa - sb;
            e.cout = (ua >= ub);
        end else begin
            ur     = ua + ub + int'(cin);
            sr     = sa + sb + int'(cin);
            e.cout = (ur > 255);
        end
        e.sum = ur[7:0];
        e.ovf = (sr > 127) || (sr < -128);
        e.cyc = 0;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard for all three builds; compares in order on every output take.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            for (int d = 0; d < 3; d++) sbq[d].delete();
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (o_valid[d] && o_ready[d]) begin
                    if (d == 0) pops0++;
                    if (sbq[d].size() == 0) begin
                        chk($sformatf("stray_beat_d%0d", d), 32'(o_valid[d]), 32'd0);
                    end else begin
                        e = sbq[d].pop_front();
                        chk($sformatf("sb_sum_d%0d", d),  32'(o_sum[d]),  32'(e.sum));
                        chk($sformatf("sb_cout_d%0d", d), 32'(o_cout[d]), 32'(e.cout));
                        chk($sformatf("sb_ovf_d%0d", d),  32'(o_ovf[d]),  32'(e.ovf));
                        if (d != 0 || lat_chk)
                            chk($sformatf("sb_latency_d%0d", d), 32'(cyc - e.cyc), 32'(STG[d]));
                    end
                end
                if (in_valid && i_ready[d]) begin
                    e = model(in_a, in_b, in_cin, in_sub);
                    e.cyc = cyc;
                    sbq[d].push_back(e);
                end
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int t0;
        bit got;
        in_a = v.a; in_b = v.b; in_cin = v.cin; in_sub = v.sub; in_valid = 1'b1;
        t0 = cyc;
        @(negedge clk);
        chk({v.name, "_accept"}, 32'(i_ready[0]), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (o_valid[0]) got = 1'b1;
        end
        chk({v.name, "_seen"},    32'(got), 32'd1);
        chk({v.name, "_latency"}, 32'(cyc - t0), 32'd4);
        chk({v.name, "_sum"},     32'(o_sum[0]), 32'(v.sum));
        chk({v.name, "_cout"},    32'(o_cout[0]), 32'(v.cout));
        chk({v.name, "_ovf"},     32'(o_ovf[0]), 32'(v.ovf));
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (k < 60 && (sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0) begin
            @(negedge clk);
            k++;
        end
        chk("drain_empty", 32'(sbq[0].size() + sbq[1].size() + sbq[2].size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vt [11];
        exp_t e0;
        int   nb, p0;
        bit   acc;

        vt[0]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01"};
        vt[1]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "add_7f_01"};
        vt[2]  = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_05_07"};
        vt[3]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_01"};
        vt[4]  = '{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0, "add_12_34_c"};
        vt[5]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "add_80_80"};
        vt[6]  = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, "sub_00_00"};
        vt[7]  = '{8'h00, 8'h80, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1, "sub_00_80"};
        vt[8]  = '{8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0, "sub_cin_ignored"};
        vt[9]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, "add_ff_ff_c"};
        vt[10] = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "add_carry_chain"};

        in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
        out_ready0 = 1'b1;
        rst_n = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(o_valid[0]), 32'd0);
        chk("rst_out_sum",   32'(o_sum[0]),   32'd0);
        chk("rst_out_cout",  32'(o_cout[0]),  32'd0);
        chk("rst_out_ovf",   32'(o_ovf[0]),   32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_release", 32'(i_ready[0]), 32'd1);

        // Directed vectors
        lat_chk = 1'b1;
        for (int i = 0; i < 11; i++) run_vec(vt[i]);
        drain();

        // Full throughput: 256 random beats back to back
        for (int i = 0; i < 256; i++) begin
            in_valid = 1'b1;
            in_a   = 8'($urandom);
            in_b   = 8'($urandom);
            in_cin = 1'($urandom);
            in_sub = 1'($urandom);
            @(negedge clk);
            chk("thru_in_ready",  32'(i_ready[0]), 32'd1);
            chk("thru_out_valid", 32'(o_valid[0]), 32'(i >= 4));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain();

        // Backpressure: 10 beats, consumer stalls for 5 cycles
        lat_chk = 1'b0;
        nb = 0;
        p0 = pops0;
        e0 = model(8'd3, 8'd5, 1'b0, 1'b1);
        for (int c = 0; c < 40; c++) begin
            out_ready0 = !(c >= 4 && c < 9);
            if (nb < 10) begin
                in_valid = 1'b1;
                in_a   = 8'(nb * 17 + 3);
                in_b   = 8'(nb * 29 + 5);
                in_cin = 1'(nb % 2);
                in_sub = ((nb % 3) == 0);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (c >= 4 && c < 9) begin
                chk("bp_in_ready_low", 32'(i_ready[0]), 32'd0);
                chk("bp_hold_valid",   32'(o_valid[0]), 32'd1);
                chk("bp_hold_sum",     32'(o_sum[0]),   32'(e0.sum));
                chk("bp_hold_cout",    32'(o_cout[0]),  32'(e0.cout));
            end
            if (in_valid && i_ready[0]) nb++;
            @(posedge clk); #1;
        end
        chk("bp_beats_accepted", 32'(nb), 32'd10);
        chk("bp_beats_delivered", 32'(pops0 - p0), 32'd10);
        out_ready0 = 1'b1;
        drain();

        // Random valid/ready gaps on both sides
        acc = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (!in_valid || acc) begin
                in_valid = 1'($urandom);
                in_a   = 8'($urandom);
                in_b   = 8'($urandom);
                in_cin = 1'($urandom);
                in_sub = 1'($urandom);
            end
            out_ready0 = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_valid && i_ready[0];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready0 = 1'b1;
        drain();

        // Reset mid-stream with beats in flight and the output stalled
        out_ready0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a = 8'(8'h21 * (i + 1));
            in_b = 8'h0F;
            in_cin = 1'b0;
            in_sub = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_reset_out_valid", 32'(o_valid[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_out_valid", 32'(o_valid[0]), 32'd0);
        chk("mid_reset_out_sum",   32'(o_sum[0]),   32'd0);
        chk("mid_reset_out_cout",  32'(o_cout[0]),  32'd0);
        chk("mid_reset_out_ovf",   32'(o_ovf[0]),   32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready0 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("post_reset_no_stale", 32'(o_valid[0]), 32'd0);
            @(posedge clk); #1;
        end
        lat_chk = 1'b1;
        run_vec(vt[3]);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
